// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges N_REQ writeback requesters onto a two-write-port
// register file, round-robin, with same-address deferral and x0 short-circuit.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       wb_valid,
    input  logic [N_REQ-1:0][4:0]  wb_addr,
    input  logic [N_REQ-1:0][31:0] wb_data,
    output logic [N_REQ-1:0]       wb_ready,
    output logic [4:0]             reg_addr1,
    output logic [4:0]             reg_addr2,
    output logic [31:0]            wr_data1,
    output logic [31:0]            wr_data2,
    output logic [1:0]             rdwr_config,
    output logic [7:0]             conflict_count
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } grant_t;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    last_idx;
    logic             any_acc;
    logic [N_REQ-1:0] grant_ready;
    logic [7:0]       n_conf;
    grant_t           p1;
    grant_t           p2;

    // Requester visited at position k of the priority order starting at base.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the scan, so no path leaves one unassigned (no latch).
        p1          = '0;
        p2          = '0;
        grant_ready = '0;
        n_conf      = '0;
        any_acc     = 1'b0;
        last_idx    = ptr;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_index(ptr, k);
            if (wb_valid[idx]) begin
                if (wb_addr[idx] == 5'd0) begin
                    grant_ready[idx] = 1'b1;
                    any_acc          = 1'b1;
                    last_idx         = idx;
                end else if ((p1.en && p1.addr == wb_addr[idx]) ||
                             (p2.en && p2.addr == wb_addr[idx])) begin
                    n_conf = n_conf + 8'd1;
                end else if (!p1.en) begin
                    p1.en            = 1'b1;
                    p1.addr          = wb_addr[idx];
                    p1.data          = wb_data[idx];
                    grant_ready[idx] = 1'b1;
                    any_acc          = 1'b1;
                    last_idx         = idx;
                end else if (!p2.en) begin
                    p2.en            = 1'b1;
                    p2.addr          = wb_addr[idx];
                    p2.data          = wb_data[idx];
                    grant_ready[idx] = 1'b1;
                    any_acc          = 1'b1;
                    last_idx         = idx;
                end
            end
        end

        if (!any_acc)                          ptr_next = ptr;
        else if (last_idx == PW'(N_REQ - 1))   ptr_next = '0;
        else                                   ptr_next = last_idx + 1'b1;
    end

    // Handshake is suppressed during reset so nothing is accepted that would be dropped.
    assign wb_ready = rst ? grant_ready : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr            <= '0;
            rdwr_config    <= 2'b00;
            reg_addr1      <= '0;
            reg_addr2      <= '0;
            wr_data1       <= '0;
            wr_data2       <= '0;
            conflict_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ptr         <= ptr_next;
            rdwr_config <= {p2.en, p1.en};
            if (p1.en) begin
                reg_addr1 <= p1.addr;
                wr_data1  <= p1.data;
            end
            if (p2.en) begin
                reg_addr2 <= p2.addr;
                wr_data2  <= p2.data;
            end
            if (n_conf >= 8'd255 - conflict_count) conflict_count <= 8'd255;
            else                                   conflict_count <= conflict_count + n_conf;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based
// model of the arbitration rules.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       wb_valid;
    logic [N-1:0][4:0]  wb_addr;
    logic [N-1:0][31:0] wb_data;
    logic [N-1:0]       wb_ready;
    logic [4:0]         reg_addr1, reg_addr2;
    logic [31:0]        wr_data1, wr_data2;
    logic [1:0]         rdwr_config;
    logic [7:0]         conflict_count;

    regfile_wb_arbiter #(.N_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .reg_addr1      (reg_addr1),
        .reg_addr2      (reg_addr2),
        .wr_data1       (wr_data1),
        .wr_data2       (wr_data2),
        .rdwr_config    (rdwr_config),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state (committed) and the values the coming edge will produce.
    int          m_ptr, m_cnt;
    logic [1:0]  m_cfg;
    logic [4:0]  m_a1, m_a2;
    logic [31:0] m_d1, m_d2;
    logic [N-1:0] e_ready;
    int          n_ptr, n_cnt;
    logic [1:0]  n_cfg;
    logic [4:0]  n_a1, n_a2;
    logic [31:0] n_d1, n_d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_cfg = 2'b00;
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
    endtask

    task automatic model_eval(input logic [N-1:0] v, input logic [N-1:0][4:0] a,
                              input logic [N-1:0][31:0] d);
        int   order[$];
        int   grants[$];
        logic [4:0] taken[$];
        int   conf, last, i;
        bit   hit;
        conf = 0; last = -1; e_ready = '0;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            i = order[j];
            if (v[i]) begin
                if (a[i] == 5'd0) begin
                    e_ready[i] = 1'b1;
                    last = i;
                end else begin
                    hit = 1'b0;
                    foreach (taken[t]) if (taken[t] == a[i]) hit = 1'b1;
                    if (hit) conf++;
                    else if (grants.size() < 2) begin
                        grants.push_back(i);
                        taken.push_back(a[i]);
                        e_ready[i] = 1'b1;
                        last = i;
                    end
                end
            end
        end
        n_ptr = (last < 0) ? m_ptr : (last + 1) % N;
        n_cnt = (m_cnt + conf > 255) ? 255 : m_cnt + conf;
        n_cfg = (grants.size() == 0) ? 2'b00 : (grants.size() == 1) ? 2'b01 : 2'b11;
        n_a1 = m_a1; n_d1 = m_d1; n_a2 = m_a2; n_d2 = m_d2;
        if (grants.size() > 0) begin n_a1 = a[grants[0]]; n_d1 = d[grants[0]]; end
        if (grants.size() > 1) begin n_a2 = a[grants[1]]; n_d2 = d[grants[1]]; end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cfg"}, 32'(rdwr_config), 32'(m_cfg));
        check({tag, "_a1"},  32'(reg_addr1), 32'(m_a1));
        check({tag, "_a2"},  32'(reg_addr2), 32'(m_a2));
        check({tag, "_d1"},  wr_data1, m_d1);
        check({tag, "_d2"},  wr_data2, m_d2);
        check({tag, "_cnt"}, 32'(conflict_count), 32'(m_cnt));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input logic [N-1:0] v,
                        input logic [N-1:0][4:0] a, input logic [N-1:0][31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
        model_eval(v, a, d);
        #1;
        check({tag, "_ready"}, 32'(wb_ready), 32'(e_ready));
        @(posedge clk);
        #1;
        m_ptr = n_ptr; m_cnt = n_cnt; m_cfg = n_cfg;
        m_a1 = n_a1; m_a2 = n_a2; m_d1 = n_d1; m_d2 = n_d2;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        check({tag, "_ready"}, 32'(wb_ready), 32'd0);
        wb_valid = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0]       rv;
        logic [N-1:0][4:0]  ra;
        logic [N-1:0][31:0] rd;

        rst = 1'b0;
        wb_valid = '1;
        wb_addr  = {5'd3, 5'd2, 5'd1};
        wb_data  = '0;
        model_reset();
        #12;
        check_outputs("rst");
        check("rst_ready", 32'(wb_ready), 32'd0);
        @(negedge clk);
        wb_valid = '0;
        rst = 1'b1;

        // Single ALU write.
        step("r025", 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hA5});
        check("r025_a1_lit", 32'(reg_addr1), 32'd5);
        check("r025_d1_lit", wr_data1, 32'hA5);
        check("r025_cfg_lit", 32'(rdwr_config), 32'd1);
        do_reset("rst_b");

        // All three requesters, two ports; remainder wins on the next cycle.
        step("r026a", 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        check("r026_cfg_lit", 32'(rdwr_config), 32'd3);
        check("r026_a2_lit", 32'(reg_addr2), 32'd2);
        step("r026b", 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        check("r026b_a1_lit", 32'(reg_addr1), 32'd3);
        do_reset("rst_c");

        // Same-address deferral.
        step("r027a", 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB1, 32'hB0});
        check("r027_cnt_lit", 32'(conflict_count), 32'd1);
        step("r027b", 3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hB1, 32'hB0});
        check("r027b_d1_lit", wr_data1, 32'hB1);
        check("r027b_cfg_lit", 32'(rdwr_config), 32'd1);
        do_reset("rst_d");

        // x0 write accepted without a port; lone grant lands on port 1.
        step("r028", 3'b110, {5'd4, 5'd0, 5'd0}, {32'hC4, 32'hC0, 32'h0});
        check("r028_cfg_lit", 32'(rdwr_config), 32'd1);
        check("r028_a1_lit", 32'(reg_addr1), 32'd4);
        do_reset("rst_e");

        // Conflict counter saturation.
        for (int n = 0; n < 257; n++)
            step("r029", 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'(n), 32'(n + 1000)});
        check("r029_cnt_lit", 32'(conflict_count), 32'd255);

        // Asynchronous reset while a grant is on the outputs.
        wb_valid = 3'b001; wb_addr = {5'd0, 5'd0, 5'd9}; wb_data = {32'h0, 32'h0, 32'hD9};
        @(posedge clk);
        #2;
        check("r030_pre_cfg", 32'(rdwr_config), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("r030_now");
        check("r030_ready", 32'(wb_ready), 32'd0);
        @(posedge clk);
        #1;
        check("r030_held_cfg", 32'(rdwr_config), 32'd0);
        @(negedge clk);
        wb_valid = '0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("r030_post_cfg", 32'(rdwr_config), 32'd0);
        @(negedge clk);

        // Randomized traffic over a small address range to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            rv = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ra[i] = 5'($urandom_range(0, 3));
                rd[i] = $urandom;
            end
            if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
            else step("rnd", rv, ra, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, giving the number of writeback requesters; index 0 = ALU, 1 = load unit, 2 = CSR unit.
REQ-002 SHALL have port clk  input  1  -- single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  -- reset is asynchronous and active-low.
REQ-004 SHALL have port wb_valid  input  N_REQ  -- per-requester write request.
REQ-005 SHALL have port wb_addr  input  N_REQ x 5  -- destination register index per requester.
REQ-006 SHALL have port wb_data  input  N_REQ x 32  -- write data per requester.
REQ-007 SHALL have port wb_ready  output  N_REQ  -- combinational accept; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have port reg_addr1 / reg_addr2  output  5 each  -- register file port addresses.
REQ-009 SHALL have port wr_data1 / wr_data2  output  32 each  -- register file write data.
REQ-010 SHALL have port rdwr_config  output  2  -- bit0 = write enable port 1; bit1 = write enable port 2.
REQ-011 SHALL have port conflict_count  output  8  -- saturating count of same-address deferrals.

Function
REQ-012 SHALL keep a round-robin pointer ptr in 0..N_REQ-1; the priority order each cycle is ptr, ptr+1, ... (mod N_REQ).
REQ-013 SHALL scan valid requesters in priority order: first non-x0 request takes port 1, second takes port 2, and any further requests get wb_ready=0.
REQ-014 SHALL accept a request with wb_addr=0 (wb_ready=1) without consuming a port, and SHALL NOT produce any write enable for it.
REQ-015 SHALL, when a later-priority request targets the same nonzero address as an already-granted request in that cycle, hold its wb_ready=0 and increment conflict_count by 1, saturating at 255.
REQ-016 SHALL present an accepted transfer on the register file outputs on the next clock edge, with a latency of exactly 1 cycle; enables are high for one cycle per transfer.
REQ-017 SHALL register rdwr_config to 2'b00 in any cycle with no port grant; addr/data outputs hold their last values when not enabled.
REQ-018 SHALL, when only port 2 would be used, instead place the single grant on port 1 (rdwr_config=2'b01), never 2'b10.
REQ-019 SHALL, when at least one requester is accepted, advance ptr to (index of last accepted requester + 1) mod N_REQ, and SHALL leave ptr unchanged otherwise.
REQ-020 SHALL grant any continuously valid, non-conflicting requester within N_REQ cycles (no starvation).
REQ-021 SHALL have wb_ready depend only on the current wb_valid, wb_addr and ptr, with no combinational path from outputs.

Reset
REQ-022 SHALL, on rst low, asynchronously set ptr=0, rdwr_config=2'b00, reg_addr1/2=0, wr_data1/2=0 and conflict_count=0.
REQ-023 SHALL force wb_ready=0 while rst is low; a transfer in flight when reset asserts SHALL be dropped, with no write after release.
REQ-024 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-025 SHALL show: only req0 valid, addr 5, data 0xA5 -> wb_ready=001; next cycle reg_addr1=5, wr_data1=0xA5, rdwr_config=01; ptr=1.
REQ-026 SHALL show: all three valid (addrs 1/2/3), ptr=0 -> ready=011; ports get addr 1 and 2, config 11; next cycle ptr=2, req2 granted on port 1.
REQ-027 SHALL show: req0 and req1 both addr 7, ptr=0 -> ready=001, conflict_count=1; next cycle req1 granted, config 01.
REQ-028 SHALL show: req1 addr 0 plus req2 addr 4 -> ready=110; next cycle only port 1 enabled, with addr 4 (config 01).
REQ-029 SHALL show: 256 consecutive conflict cycles -> conflict_count=255 (saturated, no wrap).
REQ-030 SHALL show: rst driven low mid-grant, between clock edges -> rdwr_config=00 and all outputs 0 immediately; no write enable appears after release.
